// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: clear handshake, read ports and the two write-back ports.
// The master side (decode/write-back logic) drives addresses and data; the register file is the slave.
interface register_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  logic                           clear_req;
  logic                           ready;
  logic [NUM_READ-1:0]            rd_en;
  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
  logic [1:0]                     wr_en;
  logic [2*ADDR_WIDTH-1:0]        wr_addr;
  logic [2*DATA_WIDTH-1:0]        wr_data;

  modport master (
    output clear_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  ready, rd_data
  );

  modport slave (
    input  clear_req, rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output ready, rd_data
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_READ combinational read ports with write-to-read bypass,
// two write ports (port 1 wins on address collision) and a hardware clear sequencer.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic             clock,
  input  logic             reset,
  register_file_mp_if.slave bus
);

  localparam int DEPTH       = 2 ** ADDR_WIDTH;
  localparam bit ZERO_REG_ON = (ZERO_REG != 0);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] clr_cnt_next;
  logic                  ready_q;
  logic                  ready_next;

  logic [DATA_WIDTH-1:0] storage [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_addr0;
  logic [ADDR_WIDTH-1:0] wr_addr1;
  logic [DATA_WIDTH-1:0] wr_data0;
  logic [DATA_WIDTH-1:0] wr_data1;
  logic [1:0]            wr_ok;

  assign wr_addr0 = bus.wr_addr[0 +: ADDR_WIDTH];
  assign wr_addr1 = bus.wr_addr[ADDR_WIDTH +: ADDR_WIDTH];
  assign wr_data0 = bus.wr_data[0 +: DATA_WIDTH];
  assign wr_data1 = bus.wr_data[DATA_WIDTH +: DATA_WIDTH];
  assign bus.ready = ready_q;

  // A write is legal only in IDLE and never to the hard-wired zero entry.
  always_comb begin
    wr_ok[0] = (state == IDLE) && bus.wr_en[0] && !(ZERO_REG_ON && (wr_addr0 == '0));
    wr_ok[1] = (state == IDLE) && bus.wr_en[1] && !(ZERO_REG_ON && (wr_addr1 == '0));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
      ready_q <= ready_next;
    end
  end

  // Clear walks every entry once; a clear_req arriving mid-sequence does not restart it.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    ready_next   = ready_q;
    case (state)
      CLEAR: begin
        clr_cnt_next = clr_cnt + 1'b1;
        if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
          state_next = IDLE;
          ready_next = 1'b1;
        end
      end
      IDLE: begin
        if (bus.clear_req) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
          ready_next   = 1'b0;
        end
      end
      default: begin
        state_next   = CLEAR;
        clr_cnt_next = '0;
        ready_next   = 1'b0;
      end
    endcase
  end

  // Port 1 is written after port 0 so it wins when both target the same entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR) begin
        storage[clr_cnt] <= '0;
      end else begin
        if (wr_ok[0]) storage[wr_addr0] <= wr_data0;
        if (wr_ok[1]) storage[wr_addr1] <= wr_data1;
      end
    end
  end

  // Bypass checks port 1 first so a same-cycle read matches what will be stored.
  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      logic [ADDR_WIDTH-1:0] ra;
      ra = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      if ((state == IDLE) && bus.rd_en[i] && !(ZERO_REG_ON && (ra == '0))) begin
        if (wr_ok[1] && (wr_addr1 == ra)) begin
          bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data1;
        end else if (wr_ok[0] && (wr_addr0 == ra)) begin
          bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wr_data0;
        end else begin
          bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] = storage[ra];
        end
      end
    end
  end

endmodule
